// File: rtl/load_issue_queue.sv
// Load issue queue: FIFO of load requests feeding one memory load port, one request in flight,
// responses tagged with the request ID and flagged on timeout.
module load_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mem_load_enable,
   output logic [ADDR_W-1:0] mem_load_addr,
   input  logic              mem_load_ready,
   input  logic [DATA_W-1:0] mem_load_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_tag,
   output logic              resp_err,
   output logic              busy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
   } loadReq_t;

   loadReq_t         fifoMem [DEPTH];
   logic [PTR_W-1:0] headPtr;
   logic [PTR_W-1:0] tailPtr;
   logic [CNT_W-1:0] count;
   logic [1:0]       state;
   logic [TMR_W-1:0] timer;
   logic [TAG_W-1:0] curTag;
   logic             push;
   logic             pop;

   assign req_ready = (count != CNT_W'(DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (count != '0);
   assign busy      = (state != IDLE) || (count != '0);

   // Storage needs no reset: entries are only read once count says they were written.
   always_ff @(posedge clk) begin
      if (push) fifoMem[tailPtr] <= '{addr: req_addr, tag: req_tag};
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) tailPtr <= tailPtr + PTR_W'(1);
         if (pop)  headPtr <= headPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         timer           <= '0;
         curTag          <= '0;
         mem_load_enable <= 1'b0;
         mem_load_addr   <= '0;
         resp_valid      <= 1'b0;
         resp_data       <= '0;
         resp_tag        <= '0;
         resp_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  mem_load_enable <= 1'b1;
                  mem_load_addr   <= fifoMem[headPtr].addr;
                  curTag          <= fifoMem[headPtr].tag;
                  timer           <= '0;
                  state           <= ISSUE;
               end
            end
            // Enable drops after one cycle so the memory never restarts its latency count.
            ISSUE: begin
               mem_load_enable <= 1'b0;
               state           <= WAIT;
            end
            WAIT: begin
               if (mem_load_ready) begin
                  resp_data  <= mem_load_data;
                  resp_tag   <= curTag;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  resp_data  <= '0;
                  resp_tag   <= curTag;
                  resp_err   <= 1'b1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_issue_queue.sv
// Bench for load_issue_queue: directed vector table, hand sequences for fill/backpressure/reset,
// and random traffic against a queue-based model with a behavioural memory.
module tb_load_issue_queue;
   localparam int TIMEOUT = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [15:0] req_addr;
   logic [3:0]  req_tag;
   logic        mem_load_enable, mem_load_ready;
   logic [15:0] mem_load_addr, mem_load_data;
   logic        resp_valid, resp_ready, resp_err, busy;
   logic [15:0] resp_data;
   logic [3:0]  resp_tag;

   always #5 clk = ~clk;

   load_issue_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(16), .TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
      .mem_load_enable(mem_load_enable), .mem_load_addr(mem_load_addr),
      .mem_load_ready(mem_load_ready), .mem_load_data(mem_load_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
   );

   typedef struct { logic [15:0] data; logic err; } out_t;
   typedef struct {
      logic [15:0] addr; logic [3:0] tag; int lat; logic [15:0] mdata; int hold;
      logic [15:0] expData; logic expErr; int expLat;
   } vec_t;

   logic [15:0] addrQ[$];
   logic [3:0]  tagQ[$];
   out_t        outQ[$];
   vec_t        vt[6];

   int nCmp = 0, nBad = 0, cycN = 0;
   int memLatMode = 0;
   bit memDataOvr = 0;
   logic [15:0] memDataVal = '0, memRetData = '0;
   bit memArmed = 0;
   int memLeft = 0;
   bit inflight = 0, prevEn = 0, prevValid = 0, prevAcc = 0, pushed = 0, accepted = 0;
   int enCount = 0, respRise = 0, enCyc = 0, respCyc = 0, nAccTot = 0;
   logic [15:0] hData = '0, accData = '0;
   logic [3:0]  hTag = '0, accTag = '0;
   logic        hErr = 0, accErr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cycN);
      end
   endtask

   function automatic logic [15:0] memFn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h1357;
   endfunction

   // Latency n: ready is presented during the n-th WAIT cycle; -1 means never.
   function automatic int pickLat();
      int r;
      if (memLatMode != 0) return memLatMode;
      r = int'($urandom_range(99, 0));
      if (r < 80) return int'($urandom_range(10, 1));
      if (r < 88) return int'($urandom_range(60, 11));
      if (r < 94) return int'($urandom_range(TIMEOUT, TIMEOUT - 8));
      return -1;
   endfunction

   // One clock: record handshakes for the coming posedge, then observe and drive memory at negedge.
   task automatic cyc();
      out_t o;
      int n;
      logic [15:0] d;
      bit memRdy;
      pushed   = req_valid && req_ready;
      accepted = resp_valid && resp_ready;
      if (pushed) begin addrQ.push_back(req_addr); tagQ.push_back(req_tag); end
      if (accepted) begin
         nAccTot++;
         accData = resp_data; accTag = resp_tag; accErr = resp_err;
         chk("resp_has_req", 32'(tagQ.size() != 0 && outQ.size() != 0), 32'd1);
         if (tagQ.size() != 0 && outQ.size() != 0) begin
            o = outQ.pop_front();
            chk("resp_tag", 32'(resp_tag), 32'(tagQ.pop_front()));
            chk("resp_data", 32'(resp_data), 32'(o.data));
            chk("resp_err", 32'(resp_err), 32'(o.err));
         end
         inflight = 0;
      end
      prevAcc = accepted;
      @(negedge clk);
      cycN++;
      if (mem_load_enable) begin
         enCount++; enCyc = cycN;
         chk("en_pulse_width", 32'(prevEn), 32'd0);
         chk("en_while_inflight", 32'(inflight), 32'd0);
         chk("enable_has_req", 32'(addrQ.size() != 0), 32'd1);
         if (addrQ.size() != 0) chk("issue_addr", 32'(mem_load_addr), 32'(addrQ.pop_front()));
         inflight = 1;
      end
      if (resp_valid && !prevValid) begin respRise++; respCyc = cycN; end
      if (resp_valid && prevValid && !prevAcc) begin
         chk("hold_data", 32'(resp_data), 32'(hData));
         chk("hold_tag", 32'(resp_tag), 32'(hTag));
         chk("hold_err", 32'(resp_err), 32'(hErr));
      end
      prevValid = resp_valid; hData = resp_data; hTag = resp_tag; hErr = resp_err;
      memRdy = 0;
      if (memArmed) begin
         memLeft--;
         if (memLeft == 0) begin memRdy = 1; memArmed = 0; end
      end
      if (mem_load_enable && !prevEn) begin
         n = pickLat();
         d = memDataOvr ? memDataVal : memFn(mem_load_addr);
         if (n > 0) begin memArmed = 1; memLeft = n; memRetData = d; end
         o.err  = (n <= 0) || (n > TIMEOUT);
         o.data = o.err ? 16'h0 : d;
         outQ.push_back(o);
      end
      prevEn = mem_load_enable;
      mem_load_ready = memRdy;
      mem_load_data  = memRdy ? memRetData : 16'($urandom);
   endtask

   task automatic drain(input string nm);
      int g;
      req_valid = 0; resp_ready = 1; g = 0;
      while ((busy || tagQ.size() != 0) && g < 3000) begin cyc(); g++; end
      chk({nm, "_drained"}, 32'(busy == 0 && tagQ.size() == 0 && addrQ.size() == 0), 32'd1);
   endtask

   task automatic runVec(input vec_t v);
      int g, e0, r0;
      memLatMode = v.lat; memDataOvr = 1; memDataVal = v.mdata;
      e0 = enCount; r0 = respRise;
      resp_ready = (v.hold == 0);
      req_valid = 1; req_addr = v.addr; req_tag = v.tag;
      cyc();
      req_valid = 0;
      chk("vec_push", 32'(pushed), 32'd1);
      g = 0;
      while (respRise == r0 && g < 400) begin cyc(); g++; end
      chk("vec_resp_seen", 32'(respRise != r0), 32'd1);
      chk("vec_latency", 32'(respCyc - enCyc), 32'(v.expLat));
      chk("vec_enables", 32'(enCount - e0), 32'd1);
      repeat (v.hold) cyc();
      resp_ready = 1;
      cyc();
      chk("vec_accepted", 32'(accepted), 32'd1);
      chk("vec_data", 32'(accData), 32'(v.expData));
      chk("vec_tag", 32'(accTag), 32'(v.tag));
      chk("vec_err", 32'(accErr), 32'(v.expErr));
      chk("vec_idle_after", 32'({busy, resp_valid}), 32'd0);
   endtask

   initial begin
      int g, e0, r0, a0;
      rst_n = 0; req_valid = 0; req_addr = '0; req_tag = '0;
      mem_load_ready = 0; mem_load_data = '0; resp_ready = 0;
      vt[0] = '{16'h0010, 4'd3,  99,  16'hBEEF, 0,  16'hBEEF, 1'b0, 100};
      vt[1] = '{16'h1234, 4'd7,  1,   16'h0001, 0,  16'h0001, 1'b0, 2};
      vt[2] = '{16'hFFFF, 4'd15, 128, 16'hA5A5, 0,  16'hA5A5, 1'b0, 129};
      vt[3] = '{16'h0000, 4'd0,  -1,  16'hDEAD, 0,  16'h0000, 1'b1, 129};
      vt[4] = '{16'h00F0, 4'd9,  127, 16'h7777, 0,  16'h7777, 1'b0, 128};
      vt[5] = '{16'h4321, 4'd5,  3,   16'hCAFE, 20, 16'hCAFE, 1'b0, 4};

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_ctrl", 32'({mem_load_enable, resp_valid, resp_err, busy}), 32'd0);
      chk("rst_addr_data", {mem_load_addr, resp_data}, 32'd0);
      chk("rst_tag", 32'(resp_tag), 32'd0);
      rst_n = 1;
      cyc();

      for (int i = 0; i < 6; i++) runVec(vt[i]);

      // Fill: five back-to-back pushes land (one popped), then the queue reports full.
      memDataOvr = 0; memLatMode = -1; resp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_addr = 16'h0200 + 16'(i); req_tag = 4'(i);
         cyc();
         chk("fill_push", 32'(pushed), 32'd1);
      end
      chk("full_req_ready", 32'(req_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      memLatMode = 4;
      req_addr = 16'h0205; req_tag = 4'd5; g = 0;
      do begin cyc(); g++; end while (!pushed && g < 400);
      chk("full_sixth_push", 32'(pushed), 32'd1);
      chk("full_held_past_timeout", 32'(g > TIMEOUT), 32'd1);
      drain("fill");

      // Ordering / wrap: ten streamed requests come back in order.
      memLatMode = 3; a0 = nAccTot;
      for (int i = 0; i < 10; i++) begin
         req_valid = 1; req_addr = 16'h0100 + 16'(i); req_tag = 4'(i); g = 0;
         do begin cyc(); g++; end while (!pushed && g < 200);
         chk("stream_push", 32'(pushed), 32'd1);
      end
      drain("stream");
      chk("stream_count", 32'(nAccTot - a0), 32'd10);
      chk("stream_req_ready", 32'(req_ready), 32'd1);

      // Backpressure: response held, queue still accepts, no new issue.
      memLatMode = 2; resp_ready = 0; r0 = respRise;
      req_valid = 1; req_addr = 16'h0500; req_tag = 4'h5;
      cyc();
      req_valid = 0; g = 0;
      while (respRise == r0 && g < 50) begin cyc(); g++; end
      chk("bp_resp_seen", 32'(respRise != r0), 32'd1);
      e0 = enCount;
      for (int i = 0; i < 20; i++) begin
         if (i < 3) begin req_valid = 1; req_addr = 16'h0510 + 16'(i); req_tag = 4'(6 + i); end
         else req_valid = 0;
         cyc();
         if (i < 3) chk("bp_push", 32'(pushed), 32'd1);
      end
      chk("bp_no_enable", 32'(enCount - e0), 32'd0);
      chk("bp_still_valid", 32'(resp_valid), 32'd1);
      drain("bp");

      // Reset mid-WAIT: the late ready must not produce a response.
      memLatMode = 30; resp_ready = 1; e0 = enCount;
      req_valid = 1; req_addr = 16'h0ABC; req_tag = 4'hA;
      cyc();
      req_valid = 0; g = 0;
      while (enCount == e0 && g < 20) begin cyc(); g++; end
      chk("rstw_issued", 32'(enCount - e0), 32'd1);
      repeat (10) cyc();
      rst_n = 0;
      #1;
      chk("rstw_async_busy", 32'(busy), 32'd0);
      chk("rstw_async_ready", 32'(req_ready), 32'd1);
      addrQ.delete(); tagQ.delete(); outQ.delete(); inflight = 0;
      cyc(); cyc();
      rst_n = 1;
      r0 = respRise; e0 = enCount;
      repeat (40) cyc();
      chk("rstw_no_resp", 32'(respRise - r0), 32'd0);
      chk("rstw_no_enable", 32'(enCount - e0), 32'd0);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_req_ready", 32'(req_ready), 32'd1);

      // Random traffic against the queue model.
      memLatMode = 0; memDataOvr = 0; a0 = nAccTot; req_valid = 0; pushed = 0;
      begin
         int nPush;
         nPush = 0;
         for (int c = 0; c < 1500; c++) begin
            if (!req_valid || pushed) begin
               req_valid = ($urandom_range(99, 0) < 40);
               req_addr  = 16'($urandom);
               req_tag   = 4'($urandom);
            end
            resp_ready = ($urandom_range(99, 0) < 70);
            cyc();
            if (pushed) nPush++;
         end
         drain("rand");
         chk("rand_count", 32'(nAccTot - a0), 32'(nPush));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
